// File: rtl/antirrebote_botones_pkg.sv
// Shared definitions for the button debouncer: channel FSM states, default
// timing and the channel index map used by the calculator.
package antirrebote_botones_pkg;

  typedef enum logic {
    ESTABLE  = 1'b0,
    CONTANDO = 1'b1
  } estado_t;

  localparam int CONTADOR_MAX_DEF = 500000;  // 10 ms at 50 MHz
  localparam int ANCHO_CNT_DEF    = 19;

  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 2;

endpackage

// File: rtl/antirrebote_botones_canal.sv
// One button channel: 2-flop synchronizer, stability counter FSM, debounced
// level and a one-cycle strobe on each accepted press.
module antirrebote_canal
  import antirrebote_botones_pkg::*;
#(
  parameter int CONTADOR_MAX = CONTADOR_MAX_DEF,
  parameter int ANCHO_CNT    = ANCHO_CNT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  output logic nivel,
  output logic pulso,
  output logic ocupado
);

  localparam logic [ANCHO_CNT-1:0] CNT_ULTIMO = ANCHO_CNT'(CONTADOR_MAX - 1);

  logic                 sinc1, sinc2;
  estado_t              estado, estado_sig;
  logic [ANCHO_CNT-1:0] cnt, cnt_sig;
  logic                 nivel_sig, pulso_sig;

  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of its source; with blocking, sinc2 would see boton directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sinc1 <= 1'b0;
      sinc2 <= 1'b0;
    end else begin
      sinc1 <= boton;
      sinc2 <= sinc1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= ESTABLE;
      cnt    <= '0;
      nivel  <= 1'b0;
      pulso  <= 1'b0;
    end else begin
      estado <= estado_sig;
      cnt    <= cnt_sig;
      nivel  <= nivel_sig;
      pulso  <= pulso_sig;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    estado_sig = estado;
    cnt_sig    = cnt;
    nivel_sig  = nivel;
    pulso_sig  = 1'b0;
    unique case (estado)
      ESTABLE: begin
        cnt_sig = '0;
        if (sinc2 != nivel) begin
          estado_sig = CONTANDO;
          cnt_sig    = ANCHO_CNT'(1);
        end
      end
      CONTANDO: begin
        if (sinc2 == nivel) begin
          // Input bounced back before the count completed: glitch rejected.
          estado_sig = ESTABLE;
          cnt_sig    = '0;
        end else if (cnt == CNT_ULTIMO) begin
          estado_sig = ESTABLE;
          cnt_sig    = '0;
          nivel_sig  = sinc2;
          pulso_sig  = sinc2;
        end else begin
          cnt_sig = cnt + ANCHO_CNT'(1);
        end
      end
      default: begin
        estado_sig = ESTABLE;
        cnt_sig    = '0;
      end
    endcase
  end

  assign ocupado = (cnt != '0);

endmodule

// File: rtl/antirrebote_botones.sv
// Debounces the calculator's push buttons (A, B, OP) into clean levels and
// single-cycle load strobes. Optional ANTIRREBOTE_EXCLUSIVO_EN: one strobe per cycle.
module antirrebote_botones
  import antirrebote_botones_pkg::*;
#(
  parameter int N_BOTONES    = 3,
  parameter int CONTADOR_MAX = CONTADOR_MAX_DEF,
  parameter int ANCHO_CNT    = ANCHO_CNT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BOTONES-1:0] botones_in,
  output logic [N_BOTONES-1:0] botones_nivel,
  output logic [N_BOTONES-1:0] botones_pulso,
  output logic                 ocupado
);

  logic [N_BOTONES-1:0] pulso_canal;
  logic [N_BOTONES-1:0] ocupado_canal;

  for (genvar i = 0; i < N_BOTONES; i++) begin : g_canal
    antirrebote_canal #(
      .CONTADOR_MAX(CONTADOR_MAX),
      .ANCHO_CNT   (ANCHO_CNT)
    ) u_canal (
      .clk    (clk),
      .reset  (reset),
      .boton  (botones_in[i]),
      .nivel  (botones_nivel[i]),
      .pulso  (pulso_canal[i]),
      .ocupado(ocupado_canal[i])
    );
  end

  assign ocupado = |ocupado_canal;

`ifdef ANTIRREBOTE_EXCLUSIVO_EN
  // Isolate the lowest set bit so the calculator never sees two loads at once.
  assign botones_pulso = pulso_canal & (~pulso_canal + N_BOTONES'(1));
`else
  assign botones_pulso = pulso_canal;
`endif

endmodule

// File: tb/tb_antirrebote_botones.sv
// Randomized and directed bench for antirrebote_botones with CONTADOR_MAX = 4,
// checked cycle by cycle against a run-length reference model.
module tb_antirrebote_botones;

  localparam int N   = 3;
  localparam int MAX = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] botones_in;
  logic [N-1:0] botones_nivel;
  logic [N-1:0] botones_pulso;
  logic         ocupado;

  antirrebote_botones #(
    .N_BOTONES   (N),
    .CONTADOR_MAX(MAX),
    .ANCHO_CNT   (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .botones_in   (botones_in),
    .botones_nivel(botones_nivel),
    .botones_pulso(botones_pulso),
    .ocupado      (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once MAX consecutive synchronized
  // samples all disagree with the current level; the synchronizer is a 2-deep delay.
  logic [N-1:0] d1, d2;
  logic [N-1:0] exp_nivel, exp_pulso;
  logic         exp_ocup;
  logic [N-1:0] ultimo;
  int           racha [N];
  int           n_pulsos [N];

  task automatic modelo_reset();
    d1 = '0; d2 = '0; exp_nivel = '0; exp_pulso = '0; exp_ocup = 1'b0; ultimo = '0;
    for (int i = 0; i < N; i++) racha[i] = 0;
  endtask

  task automatic modelo_paso(input logic [N-1:0] raw);
    logic [N-1:0] s;
    logic [N-1:0] subida;
    if (reset) begin
      modelo_reset();
      return;
    end
    s  = d2;
    d2 = d1;
    d1 = raw;
    subida = '0;
    for (int i = 0; i < N; i++) begin
      if (s[i] == ultimo[i]) racha[i]++;
      else begin
        ultimo[i] = s[i];
        racha[i]  = 1;
      end
      if (ultimo[i] != exp_nivel[i] && racha[i] == MAX) begin
        exp_nivel[i] = ultimo[i];
        subida[i]    = ultimo[i];
      end
    end
    exp_ocup = (ultimo != exp_nivel);
`ifdef ANTIRREBOTE_EXCLUSIVO_EN
    exp_pulso = '0;
    for (int i = 0; i < N; i++) begin
      if (subida[i] && exp_pulso == '0) exp_pulso[i] = 1'b1;
    end
`else
    exp_pulso = subida;
`endif
  endtask

  task automatic limpiar_pulsos();
    for (int i = 0; i < N; i++) n_pulsos[i] = 0;
  endtask

  // One clock: drive raw levels, step the model on the edge, compare on the falling edge.
  task automatic ciclo(input logic [N-1:0] raw);
    botones_in = raw;
    @(posedge clk);
    modelo_paso(raw);
    @(negedge clk);
    check("nivel", 32'(botones_nivel), 32'(exp_nivel));
    check("pulso", 32'(botones_pulso), 32'(exp_pulso));
    check("ocupado", 32'(ocupado), 32'(exp_ocup));
    for (int i = 0; i < N; i++) if (botones_pulso[i]) n_pulsos[i]++;
  endtask

  task automatic repetir(input logic [N-1:0] raw, input int n);
    for (int k = 0; k < n; k++) ciclo(raw);
  endtask

  initial begin
    logic [N-1:0] aleat;
    int           hold [N];

    reset      = 1'b1;
    botones_in = '0;
    modelo_reset();
    limpiar_pulsos();
    repetir(3'b000, 3);
    reset = 1'b0;

    // Idle after reset.
    repetir(3'b000, 20);

    // Single press on A, then short glitch on B while A is held.
    limpiar_pulsos();
    repetir(3'b001, 10);
    repetir(3'b011, 3);
    repetir(3'b001, 8);
    check("press_a_pulses", 32'(n_pulsos[0]), 32'd1);
    check("glitch_b_pulses", 32'(n_pulsos[1]), 32'd0);
    repetir(3'b000, 10);

    // Simultaneous A + OP.
    repetir(3'b101, 10);
    repetir(3'b000, 10);

    // Long hold on OP, then release: one pulse total, none on release.
    limpiar_pulsos();
    repetir(3'b100, 50);
    check("hold_op_pulses", 32'(n_pulsos[2]), 32'd1);
    repetir(3'b000, 12);
    check("release_op_pulses", 32'(n_pulsos[2]), 32'd1);

    // Reset mid-count on A, button still held afterwards.
    limpiar_pulsos();
    repetir(3'b001, 4);
    reset = 1'b1;
    repetir(3'b001, 3);
    check("reset_mid_pulses", 32'(n_pulsos[0]), 32'd0);
    reset = 1'b0;
    repetir(3'b001, 10);
    check("after_reset_pulses", 32'(n_pulsos[0]), 32'd1);
    repetir(3'b000, 10);

    // B toggling every cycle never settles.
    limpiar_pulsos();
    for (int k = 0; k < 20; k++) ciclo((k % 2 == 0) ? 3'b010 : 3'b000);
    repetir(3'b000, 3);
    check("toggle_b_pulses", 32'(n_pulsos[1]), 32'd0);
    repetir(3'b000, 10);

    // Random bouncing: each channel holds a level for 1..8 cycles.
    aleat = '0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          aleat[i] = 1'($urandom_range(0, 1));
          hold[i]  = int'($urandom_range(1, 8));
        end
        hold[i]--;
      end
      if (k == 300) reset = 1'b1;
      if (k == 302) reset = 1'b0;
      ciclo(aleat);
    end
    repetir(3'b000, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
